// File: rtl/kernel_top_vec_if.sv
// kernel_top_vec_if: shared valid/ready stream bundle for the vector kernel,
// carrying both operand streams in and the result stream out.
interface kernel_top_vec_if #(
  parameter int STREAMW = 32,
  parameter int NLANES  = 4
);
  logic                      ivalid;
  logic                      iready;
  logic [NLANES*STREAMW-1:0] in1;
  logic [NLANES*STREAMW-1:0] in2;
  logic                      ovalid;
  logic                      oready;
  logic [NLANES*STREAMW-1:0] out;
  logic                      olast;
  modport slave  (input ivalid, in1, in2, oready, output iready, ovalid, out, olast);
  modport master (output ivalid, in1, in2, oready, input iready, ovalid, out, olast);
endinterface

// File: rtl/kernel_top_vec.sv
// kernel_top_vec: NLANES lockstep lanes applying a binary op through a DEPTH-stage
// elastic pipeline, with an element counter flagging the last word of each stream.
module kernel_top_vec #(
  parameter int STREAMW = 32,
  parameter int NLANES  = 4,
  parameter int DEPTH   = 3,
  parameter int OP      = 0,
  parameter int NELEM   = 1024
) (
  input logic             clk,
  input logic             rst,
  kernel_top_vec_if.slave s
);
  localparam int W  = NLANES * STREAMW;
  localparam int CW = NELEM > 1 ? $clog2(NELEM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NELEM - 1);
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [W-1:0]     d [DEPTH];
  logic [W-1:0]     res;
  logic [CW-1:0]    ocnt;
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [STREAMW-1:0] a, b;
    assign a = s.in1[k*STREAMW +: STREAMW];
    assign b = s.in2[k*STREAMW +: STREAMW];
    assign res[k*STREAMW +: STREAMW] = OP == 2 ? a * b : OP == 1 ? a - b : a + b;
  end
  // a stage advances if it or any stage downstream of it is empty, or the sink drains
  for (genvar i = 0; i < DEPTH; i++) begin : g_adv
    assign adv[i] = s.oready | ~&v[DEPTH-1:i];
  end
  assign s.iready = adv[0];
  assign s.ovalid = v[DEPTH-1];
  assign s.out    = d[DEPTH-1];
  assign s.olast  = v[DEPTH-1] & (ocnt == LAST);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      if (adv[0]) begin
        v[0] <= s.ivalid;
        d[0] <= res;
      end
      for (int i = 1; i < DEPTH; i++)
        if (adv[i]) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ocnt <= '0;
    else if (s.ovalid & s.oready) ocnt <= ocnt == LAST ? '0 : ocnt + 1'b1;
  end
endmodule

// File: tb/tb_kernel_top_vec.sv
// tb_kernel_top_vec: four instances (add, sub, mul, add with NELEM=4) share one stimulus;
// a negedge monitor pops per-instance expected queues filled when each vector is accepted.
module tb_kernel_top_vec;
  localparam int SW = 32;
  localparam int NL = 4;
  localparam int W  = SW * NL;
  localparam int D  = 3;
  localparam int NI = 4;
  localparam int OPS [NI] = '{0, 1, 2, 0};
  localparam int NEL [NI] = '{1024, 1024, 1024, 4};
  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           acc;
    bit           lat;
  } item_t;
  logic clk = 0;
  logic rst = 0;
  logic ivalid = 0;
  logic oready = 0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [NI-1:0] iready_a, ovalid_a, olast_a;
  logic [W-1:0]  out_a [NI];
  item_t q [NI][$];
  int ecnt [NI];
  int nlast [NI];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int nsent = 0;
  bit chk_lat = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar i = 0; i < NI; i++) begin : g
    kernel_top_vec_if #(.STREAMW(SW), .NLANES(NL)) bus ();
    assign bus.ivalid  = ivalid;
    assign bus.in1     = in1;
    assign bus.in2     = in2;
    assign bus.oready  = oready;
    assign iready_a[i] = bus.iready;
    assign ovalid_a[i] = bus.ovalid;
    assign olast_a[i]  = bus.olast;
    assign out_a[i]    = bus.out;
    kernel_top_vec #(.STREAMW(SW), .NLANES(NL), .DEPTH(D), .OP(OPS[i]), .NELEM(NEL[i])) u (
      .clk(clk),
      .rst(rst),
      .s(bus)
    );
  end
  function automatic logic [W-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [SW-1:0] x, y;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      x = a[k*SW +: SW];
      y = b[k*SW +: SW];
      r[k*SW +: SW] = op == 0 ? x + y : op == 1 ? x - y : x * y;
    end
    return r;
  endfunction
  function automatic logic [W-1:0] gen1(input int n);
    logic [W-1:0] r;
    for (int k = 0; k < NL; k++) r[k*SW +: SW] = 32'(32'h1000 * n + 7 * k + 1);
    return r;
  endfunction
  function automatic logic [W-1:0] gen2(input int n);
    logic [W-1:0] r;
    for (int k = 0; k < NL; k++) r[k*SW +: SW] = 32'(n + 3 * k);
    return r;
  endfunction
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk)
    if (rst)
      for (int i = 0; i < NI; i++)
        if (ovalid_a[i] && oready) begin
          item_t e;
          if (q[i].size() == 0) begin
            checks++;
            $display("FAIL unexpected_out%0d: got %h expected no output", i, out_a[i]);
          end else begin
            e = q[i].pop_front();
            check($sformatf("sb_data%0d", i), out_a[i], e.data);
            check($sformatf("sb_last%0d", i), W'(olast_a[i]), W'(e.last));
            if (e.lat) check($sformatf("sb_latency%0d", i), W'(cyc + 1 - e.acc), W'(D));
            if (olast_a[i]) nlast[i]++;
          end
        end
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    ivalid = v;
    in1 = a;
    in2 = b;
    oready = r;
    #1;
    for (int i = 0; i < NI; i++)
      if (v && iready_a[i]) begin
        q[i].push_back('{data: model(OPS[i], a, b), last: (ecnt[i] % NEL[i]) == NEL[i] - 1,
                         acc: cyc + 1, lat: chk_lat});
        ecnt[i]++;
      end
    if (v && iready_a[0]) nsent++;
    @(posedge clk);
    #1;
  endtask
  task automatic send_gen(input logic v, input logic r);
    cycle(v, gen1(nsent), gen2(nsent), r);
  endtask
  task automatic drain(input int n);
    for (int j = 0; j < n; j++) cycle(0, '0, '0, 1);
  endtask
  task automatic clear_sb();
    for (int i = 0; i < NI; i++) begin
      q[i].delete();
      ecnt[i] = 0;
      nlast[i] = 0;
    end
    nsent = 0;
  endtask
  task automatic do_reset();
    ivalid = 0;
    oready = 0;
    #2;
    rst = 0;
    clear_sb();
    repeat (2) @(posedge clk);
    #3;
    rst = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic drained(input string name);
    for (int i = 0; i < NI; i++) check($sformatf("%s_drained%0d", name, i), W'(q[i].size()), '0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] a, b, e, snap;
    int guard;
    do_reset();
    check("rst_ovalid", W'(ovalid_a), '0);
    check("rst_olast", W'(olast_a), '0);
    check("rst_out", out_a[0], '0);
    check("rst_iready", W'(iready_a), W'(4'hF));
    // stream: lane k = (10+k) + 5
    for (int k = 0; k < NL; k++) begin
      a[k*SW +: SW] = 32'(10 + k);
      b[k*SW +: SW] = 32'd5;
      e[k*SW +: SW] = 32'(15 + k);
    end
    chk_lat = 1;
    for (int j = 0; j < 8; j++) begin
      cycle(1, a, b, 1);
      if (j < 2) check("stream_ovalid_early", W'(ovalid_a[0]), '0);
      if (j == 2) begin
        check("stream_ovalid_first", W'(ovalid_a[0]), W'(1));
        check("stream_out", out_a[0], e);
      end
    end
    drain(4);
    chk_lat = 0;
    drained("stream");
    // wrap-around arithmetic
    do_reset();
    a = {32'd7, 32'h0001_0000, 32'd3, 32'hFFFF_FFFF};
    b = {32'd9, 32'h0001_0000, 32'd5, 32'd2};
    cycle(1, a, b, 1);
    drain(2);
    check("wrap_add", W'(out_a[0][31:0]), W'(32'h0000_0001));
    check("wrap_sub", W'(out_a[1][63:32]), W'(32'hFFFF_FFFE));
    check("wrap_mul", W'(out_a[2][95:64]), W'(32'h0000_0000));
    drain(3);
    drained("wrap");
    // back-pressure: fill with oready low
    do_reset();
    snap = '0;
    for (int j = 0; j < 6; j++) begin
      send_gen(1, 0);
      check("bp_iready", W'(iready_a[0]), W'(j < 2 ? 1 : 0));
      if (j == 2) snap = out_a[0];
      if (j > 2) check("bp_out_stable", out_a[0], snap);
    end
    check("bp_accepts", W'(nsent), W'(3));
    oready = 1;
    #1;
    check("bp_release_iready", W'(iready_a[0]), W'(1));
    check("bp_release_ovalid", W'(ovalid_a[0]), W'(1));
    send_gen(1, 1);
    check("bp_release_accepts", W'(nsent), W'(4));
    send_gen(0, 0);
    drain(5);
    drained("bp");
    // olast with random stalls
    do_reset();
    guard = 0;
    while (nsent < 10 && guard < 200) begin
      send_gen(1, 1'($urandom_range(0, 1)));
      guard++;
    end
    check("olast_sent", W'(nsent), W'(10));
    drain(6);
    check("olast_count", W'(nlast[3]), W'(2));
    check("olast_ocnt", W'(g[3].u.ocnt), W'(2));
    drained("olast");
    // mid-flight reset
    do_reset();
    repeat (3) send_gen(1, 1);
    drain(4);
    send_gen(1, 0);
    send_gen(1, 0);
    cycle(0, '0, '0, 0);
    check("mid_pre_olast", W'(olast_a[3]), W'(1));
    #3;
    rst = 0;
    clear_sb();
    #1;
    check("mid_ovalid", W'(ovalid_a), '0);
    check("mid_olast", W'(olast_a), '0);
    check("mid_iready", W'(iready_a), W'(4'hF));
    repeat (2) @(posedge clk);
    #3;
    rst = 1;
    @(posedge clk);
    #1;
    repeat (4) send_gen(1, 1);
    drain(5);
    check("mid_olast_count", W'(nlast[3]), W'(1));
    drained("mid");
    // bubbles
    do_reset();
    chk_lat = 1;
    for (int j = 0; j < 6; j++) begin
      send_gen(1'(j % 2 == 0), 1);
      check("bubble_iready", W'(iready_a), W'(4'hF));
    end
    drain(5);
    chk_lat = 0;
    check("bubble_sent", W'(nsent), W'(3));
    drained("bubble");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
